// File: rtl/mem_store_unit_pkg.sv
// Shared definitions for the store unit: StoreWidth encoding and FSM states.
// The StoreWidth encoding matches the load-extraction path.
package mem_store_unit_pkg;

    localparam logic [1:0] SW_WORD  = 2'd0;
    localparam logic [1:0] SW_BYTE  = 2'd1;
    localparam logic [1:0] SW_HALF  = 2'd2;
    localparam logic [1:0] SW_UNDEF = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_MRG,
        ST_WR,
        ST_FLT
    } store_state_e;

endpackage

// File: rtl/store_lane_merge.sv
// Combinational lane merge: places the store data into the lanes selected by
// width and the low address bits, keeping the remaining bits of old_word.
module store_lane_merge
    import mem_store_unit_pkg::*;
#(
    parameter int unsigned DATA_BITS = 32
) (
    input  logic [DATA_BITS-1:0] old_word,
    input  logic [DATA_BITS-1:0] new_data,
    input  logic [1:0]           width,
    input  logic [1:0]           addr,
    output logic [DATA_BITS-1:0] merged,
    output logic [3:0]           be
);

    // Select the modified lanes and splice the new data over the old word
    always_comb begin
        merged = old_word;
        be     = '0;
        case (width)
            SW_WORD: begin
                merged = new_data;
                be     = 4'b1111;
            end
            SW_BYTE: begin
                case (addr)
                    2'd0: begin merged[7:0]   = new_data[7:0]; be = 4'b0001; end
                    2'd1: begin merged[15:8]  = new_data[7:0]; be = 4'b0010; end
                    2'd2: begin merged[23:16] = new_data[7:0]; be = 4'b0100; end
                    default: begin merged[31:24] = new_data[7:0]; be = 4'b1000; end
                endcase
            end
            SW_HALF: begin
                if (addr[1]) begin
                    merged[31:16] = new_data[15:0];
                    be            = 4'b1100;
                end else begin
                    merged[15:0]  = new_data[15:0];
                    be            = 4'b0011;
                end
            end
            default: begin
                merged = old_word;
                be     = '0;
            end
        endcase
    end

endmodule

// File: rtl/mem_store_unit.sv
// Store unit for a word-wide data memory without byte enables. Word stores
// write directly; byte/halfword stores read-modify-write the containing word.
// Optional feature macro: STORE_ALIGN_CHECK_EN (misaligned stores fault).
module mem_store_unit
    import mem_store_unit_pkg::*;
#(
    parameter int unsigned DATA_BITS = 32,
    parameter int unsigned ADDR_BITS = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [DATA_BITS-1:0] data,
    input  logic [1:0]           StoreWidth,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic                 mem_rd_en,
    input  logic [DATA_BITS-1:0] mem_rdata,
    output logic                 mem_wr_en,
    output logic [DATA_BITS-1:0] mem_wdata,
    output logic [3:0]           mem_be,
    output logic                 done,
    output logic                 fault
);

    store_state_e         state_q;
    logic [1:0]           addr_lo_q;
    logic [DATA_BITS-1:0] data_q;
    logic [1:0]           width_q;
    logic [ADDR_BITS-1:0] mem_addr_q;
    logic                 rd_en_q;
    logic                 wr_en_q;
    logic                 done_q;
    logic                 fault_q;
    logic                 misaligned;
    logic [DATA_BITS-1:0] merged;
    logic [3:0]           merged_be;

`ifdef STORE_ALIGN_CHECK_EN
    assign misaligned = ((StoreWidth == SW_HALF) && addr[0]) ||
                        ((StoreWidth == SW_WORD) && (addr[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    // Merge operates only on registered request fields and the memory read
    // data; in WR the width is word, so the merge simply passes data_q.
    store_lane_merge #(
        .DATA_BITS (DATA_BITS)
    ) u_merge (
        .old_word (mem_rdata),
        .new_data (data_q),
        .width    (width_q),
        .addr     (addr_lo_q),
        .merged   (merged),
        .be       (merged_be)
    );

    // Store FSM: captures the request on accept and sequences memory strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            addr_lo_q  <= '0;
            data_q     <= '0;
            width_q    <= '0;
            mem_addr_q <= '0;
            rd_en_q    <= 1'b0;
            wr_en_q    <= 1'b0;
            done_q     <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            rd_en_q <= 1'b0;
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        addr_lo_q  <= addr[1:0];
                        data_q     <= data;
                        width_q    <= StoreWidth;
                        mem_addr_q <= {addr[ADDR_BITS-1:2], 2'b00};
                        if ((StoreWidth == SW_UNDEF) || misaligned) begin
                            state_q <= ST_FLT;
                            done_q  <= 1'b1;
                            fault_q <= 1'b1;
                        end else if (StoreWidth == SW_WORD) begin
                            state_q <= ST_WR;
                            wr_en_q <= 1'b1;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_RD;
                            rd_en_q <= 1'b1;
                        end
                    end
                end
                ST_RD: begin
                    state_q <= ST_MRG;
                    wr_en_q <= 1'b1;
                    done_q  <= 1'b1;
                end
                ST_MRG, ST_WR, ST_FLT: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign mem_addr  = mem_addr_q;
    assign mem_rd_en = rd_en_q;
    assign mem_wr_en = wr_en_q;
    assign done      = done_q;
    assign fault     = fault_q;
    // Write data and lanes are only meaningful while the write strobe is up
    assign mem_wdata = wr_en_q ? merged : '0;
    assign mem_be    = wr_en_q ? merged_be : '0;

endmodule

// File: tb/tb_mem_store_unit.sv
// Self-checking bench for mem_store_unit: directed cases plus random stores
// checked against a byte-level memory model.
module tb_mem_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  StoreWidth;
    logic [31:0] mem_addr;
    logic        mem_rd_en;
    logic [31:0] mem_rdata;
    logic        mem_wr_en;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        done;
    logic        fault;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned wr_count = 0;

    logic [31:0] mem     [16];
    logic [31:0] ref_mem [16];

    always #5 clk = ~clk;

    mem_store_unit #(
        .DATA_BITS (32),
        .ADDR_BITS (32)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .addr       (addr),
        .data       (data),
        .StoreWidth (StoreWidth),
        .mem_addr   (mem_addr),
        .mem_rd_en  (mem_rd_en),
        .mem_rdata  (mem_rdata),
        .mem_wr_en  (mem_wr_en),
        .mem_wdata  (mem_wdata),
        .mem_be     (mem_be),
        .done       (done),
        .fault      (fault)
    );

    // Synchronous data memory, 16 words, no byte enables
    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= mem[mem_addr[5:2]];
        if (mem_wr_en) begin
            mem[mem_addr[5:2]] <= mem_wdata;
            wr_count <= wr_count + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: decides fault, builds the new word byte by byte
    function automatic void model(input logic [31:0] a, input logic [31:0] d,
                                  input logic [1:0] w, input logic [31:0] old,
                                  output logic flt, output logic [31:0] nw,
                                  output logic [3:0] be);
        logic [7:0] bytes [4];
        int unsigned lane;
        flt = (w == 2'd3);
`ifdef STORE_ALIGN_CHECK_EN
        if (w == 2'd2 && a[0]) flt = 1'b1;
        if (w == 2'd0 && (a % 4) != 0) flt = 1'b1;
`endif
        be = 4'b0000;
        if (!flt) begin
            if (w == 2'd0) be = 4'b1111;
            else if (w == 2'd1) begin lane = a % 4; be[lane] = 1'b1; end
            else be = a[1] ? 4'b1100 : 4'b0011;
        end
        for (int i = 0; i < 4; i++) begin
            bytes[i] = old[8*i +: 8];
            if (be[i]) begin
                if (w == 2'd0)      bytes[i] = d[8*i +: 8];
                else if (w == 2'd1) bytes[i] = d[7:0];
                else                bytes[i] = d[8*(i%2) +: 8];
            end
        end
        nw = {bytes[3], bytes[2], bytes[1], bytes[0]};
    endfunction

    // Issue one store starting at a negedge and check it cycle by cycle
    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] w);
        logic        flt;
        logic [31:0] nw;
        logic [3:0]  be;
        int unsigned idx;
        int unsigned n;
        idx = (a >> 2) % 16;
        model(a, d, w, ref_mem[idx], flt, nw, be);
        n = 0;
        while (!req_ready && n < 10) begin @(negedge clk); n++; end
        check_eq("ready_before", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; addr = a; data = d; StoreWidth = w;
        @(posedge clk); #1;
        req_valid = 1'b0; addr = $urandom; data = $urandom; StoreWidth = 2'($urandom);
        @(negedge clk);
        check_eq("c1_ready", {31'd0, req_ready}, 32'd0);
        check_eq("c1_rd", {31'd0, mem_rd_en}, {31'd0, !flt && w != 2'd0});
        check_eq("c1_wr", {31'd0, mem_wr_en}, {31'd0, !flt && w == 2'd0});
        check_eq("c1_done", {31'd0, done}, {31'd0, flt || w == 2'd0});
        check_eq("c1_fault", {31'd0, fault}, {31'd0, flt});
        if (!flt) check_eq("c1_addr", mem_addr, a & ~32'd3);
        if (!flt && w == 2'd0) begin
            check_eq("c1_wdata", mem_wdata, nw);
            check_eq("c1_be", {28'd0, mem_be}, {28'd0, be});
        end
        if (!flt && w != 2'd0) begin
            @(negedge clk);
            check_eq("c2_rd", {31'd0, mem_rd_en}, 32'd0);
            check_eq("c2_wr", {31'd0, mem_wr_en}, 32'd1);
            check_eq("c2_done", {31'd0, done}, 32'd1);
            check_eq("c2_fault", {31'd0, fault}, 32'd0);
            check_eq("c2_ready", {31'd0, req_ready}, 32'd0);
            check_eq("c2_addr", mem_addr, a & ~32'd3);
            check_eq("c2_wdata", mem_wdata, nw);
            check_eq("c2_be", {28'd0, mem_be}, {28'd0, be});
        end
        if (!flt) ref_mem[idx] = nw;
        @(negedge clk);
        check_eq("after_done", {31'd0, done}, 32'd0);
        check_eq("after_ready", {31'd0, req_ready}, 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_rd"}, {31'd0, mem_rd_en}, 32'd0);
        check_eq({tag, "_wr"}, {31'd0, mem_wr_en}, 32'd0);
        check_eq({tag, "_wdata"}, mem_wdata, 32'd0);
        check_eq({tag, "_be"}, {28'd0, mem_be}, 32'd0);
        check_eq({tag, "_addr"}, mem_addr, 32'd0);
        check_eq({tag, "_done"}, {31'd0, done}, 32'd0);
        check_eq({tag, "_fault"}, {31'd0, fault}, 32'd0);
        check_eq({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        int unsigned wr_snap;
        rst_n = 1'b0; req_valid = 1'b0; addr = '0; data = '0; StoreWidth = '0;
        mem_rdata = '0;
        for (int i = 0; i < 16; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        #2;
        check_all_zero("reset");
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases
        do_store(32'h100, 32'hDEADBEEF, 2'd0);
        mem[0] = 32'h11223344; ref_mem[0] = 32'h11223344;
        do_store(32'h102, 32'h000000AB, 2'd1);
        check_eq("byte_word", mem[0], 32'h11AB3344);
        mem[1] = 32'h11223344; ref_mem[1] = 32'h11223344;
        do_store(32'h106, 32'h0000CAFE, 2'd2);
        check_eq("half_word", mem[1], 32'hCAFE3344);
        do_store(32'h108, 32'h12345678, 2'd3);
        mem[0] = 32'h11223344; ref_mem[0] = 32'h11223344;
        do_store(32'h101, 32'h0000BEEF, 2'd2);
`ifdef STORE_ALIGN_CHECK_EN
        check_eq("mis_half", mem[0], 32'h11223344);
`else
        check_eq("mis_half", mem[0], 32'h1122BEEF);
`endif

        // Reset in cycle 1 of a byte store
        wr_snap = wr_count;
        req_valid = 1'b1; addr = 32'h10C; data = 32'h55; StoreWidth = 2'd1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check_eq("rst_mid_rd", {31'd0, mem_rd_en}, 32'd1);
        #2 rst_n = 1'b0;
        #1 check_all_zero("midrst");
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); @(negedge clk);
        check_eq("midrst_nowr", wr_count, wr_snap);
        check_eq("midrst_ready", {31'd0, req_ready}, 32'd1);
        check_eq("midrst_mem", mem[3], ref_mem[3]);

        // Random back-to-back stores
        for (int t = 0; t < 200; t++)
            do_store(32'h100 + ($urandom % 64), $urandom, 2'($urandom % 4));

        for (int i = 0; i < 16; i++) check_eq("memword", mem[i], ref_mem[i]);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Global timeout
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/mem_store_unit.md
# mem_store_unit

Store-side counterpart of the register-file write path: accepts a store request (address, `rt` value, width) from the execute stage and drives a word-wide synchronous data memory that has no byte enables. Word stores go straight to memory. Byte and halfword stores run a read-modify-write: read the containing word, merge the new lane, write it back. The block sits between the ALU address output and the data-memory port, and arbitrates those ports itself while busy.

## Interface
- `DATA_BITS`, 32, datapath width; only 32 is supported.
- `ADDR_BITS`, 32, byte-address width.

- `clk`  in  1  clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  store request present.
- `req_ready`  out  1  high only in IDLE; a request is accepted on `req_valid && req_ready`.
- `addr`  in  ADDR_BITS  byte address.
- `data`  in  DATA_BITS  store data (`rt`). Byte stores use `[7:0]`; halfword stores use `[15:0]`.
- `StoreWidth`  in  2  0 = word, 1 = byte, 2 = halfword, 3 = undefined.
- `mem_addr`  out  ADDR_BITS  word-aligned address, `{addr[ADDR_BITS-1:2], 2'b00}`.
- `mem_rd_en`  out  1  one-cycle read strobe.
- `mem_rdata`  in  DATA_BITS  read data, valid the cycle after `mem_rd_en`.
- `mem_wr_en`  out  1  one-cycle write strobe.
- `mem_wdata`  out  DATA_BITS  full word to write.
- `mem_be`  out  4  lanes being modified; informational, for trace and debug.
- `done`  out  1  one-cycle pulse when the request retires.
- `fault`  out  1  qualifies `done`; the store was dropped.

## Operation
- On accept, `addr`, `data` and `StoreWidth` are registered; later changes on the inputs are ignored.
- States and transitions:
  - IDLE → WR when width = 0.
  - IDLE → RD when width = 1 or 2.
  - IDLE → FLT when width = 3, or when the store is misaligned (see Configuration).
  - RD → MRG.
  - WR, MRG, FLT → IDLE.
- Per-state outputs:
  - RD asserts `mem_rd_en`.
  - MRG uses `mem_rdata` and asserts `mem_wr_en` with the merged word, plus `done`.
  - WR asserts `mem_wr_en` with `mem_wdata = data`, `mem_be = 4'b1111`, plus `done`.
  - FLT asserts `done` and `fault`. No memory strobe is issued.
- Merge rules:
  - Byte: lane k = `addr[1:0]`. `mem_wdata[8k+7:8k] = data[7:0]`; the other bits come from `mem_rdata`. `mem_be` is one-hot at bit k.
  - Halfword: `addr[1]` selects `[31:16]` (1) or `[15:0]` (0), which receives `data[15:0]`. `mem_be` is `4'b1100` or `4'b0011`.
- `mem_rd_en` and `mem_wr_en` are never high in the same cycle.
- A new request is never accepted in the cycle `done` is asserted, because `req_ready` is low then. The next accept is possible one cycle later.
- Reset:
  - All outputs are 0 during reset, except `req_ready`, which is 1 because the state is IDLE.
  - The registered `mem_*` outputs, `done` and `fault` are all 0.
  - A store interrupted by reset is abandoned. No partial write can occur, because the write is a single strobe.

## Timing
- Accept at cycle 0.
- Word store: `mem_wr_en` and `done` in cycle 1.
- Byte or halfword store: `mem_rd_en` in cycle 1, `mem_wr_en` and `done` in cycle 2.
- Fault: `done` and `fault` in cycle 1.
- All `mem_*` outputs, `done` and `fault` are driven from registers; there is no combinational path from the request inputs.
- `req_ready` is decoded from the state register only.

## Configuration
- `STORE_ALIGN_CHECK_EN` defined: misaligned stores go to FLT with no memory access.
  - Halfword is misaligned when `addr[0]` = 1.
  - Word is misaligned when `addr[1:0] != 0`.
- `STORE_ALIGN_CHECK_EN` undefined:
  - Alignment bits are ignored. A halfword uses `addr[1]` only; a word ignores `addr[1:0]`.
  - `fault` is raised only for width 3.

## Structure
- Shared package holds:
  - The `StoreWidth` encoding constants. They match the load-extraction encoding: word 0, byte 1, halfword 2.
  - The state enum: IDLE, RD, MRG, WR, FLT.
- One combinational sub-module, `store_lane_merge`, computes `mem_wdata` and `mem_be`.
  - Inputs: `old_word`, `new_data`, `width`, `addr[1:0]`.
  - The FSM instantiates it once.

## Test plan
- Word store, `addr` 0x100, `data` 0xDEADBEEF → `mem_wr_en` at cycle 1 with `mem_addr` 0x100, `mem_wdata` 0xDEADBEEF, `mem_be` 1111; `done` at cycle 1.
- Byte store, `addr` 0x102, `data` 0x000000AB, memory word 0x11223344 → `mem_rd_en` at cycle 1; at cycle 2 `mem_wdata` 0x11AB3344, `mem_be` 0100.
- Halfword store, `addr` 0x106, `data` 0x0000CAFE, memory word 0x11223344 → `mem_wdata` 0xCAFE3344, `mem_be` 1100.
- Width 3 → `done` and `fault` at cycle 1, no `mem_rd_en` or `mem_wr_en`. With `STORE_ALIGN_CHECK_EN`, a halfword to 0x101 behaves the same way. Without the macro, that halfword writes lane `[15:0]`.
- Pull `rst_n` low in cycle 1 of a byte store → all outputs 0 immediately, no `mem_wr_en` ever issued, `req_ready` 1 after release. Back-to-back requests: second accepted one cycle after the first `done`.
